// File: rtl/fpga_core.sv
// FPGA top level: a UART that echoes each received byte to the LEDs and back out, plus
// button-driven LED edits and switch status reports. I2C/GMII are parked and the PHY reset is timed.
module fpga_core #(
    parameter string TARGET = "SIM"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnu,
    input  logic       btnl,
    input  logic       btnd,
    input  logic       btnr,
    input  logic       btnc,
    input  logic [7:0] sw,
    output logic [7:0] led,
    input  logic       i2c_scl_i,
    output logic       i2c_scl_o,
    output logic       i2c_scl_t,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_t,
    input  logic       phy_rx_clk,
    input  logic [7:0] phy_rxd,
    input  logic       phy_rx_dv,
    input  logic       phy_rx_er,
    output logic       phy_gtx_clk,
    input  logic       phy_tx_clk,
    output logic [7:0] phy_txd,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic       phy_reset_n,
    input  logic       phy_int_n,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic       uart_cts,
    output logic       uart_rts
);

    localparam int CLKS_PER_BIT = (TARGET == "SIM") ? 8 : 1085;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Button vector order: {u, l, d, r, c}
    logic [4:0] btn_s1, btn_s2, btn_q, btn_edge;
    logic [7:0] sw_s1, sw_s2;
    logic       rx_s1, rx_s2, rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_q  <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            rx_q   <= 1'b1;
        end else begin
            btn_s1 <= {btnu, btnl, btnd, btnr, btnc};
            btn_s2 <= btn_s1;
            btn_q  <= btn_s2;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            rx_s1  <= uart_rxd;
            rx_s2  <= rx_s1;
            rx_q   <= rx_s2;
        end
    end

    assign btn_edge = btn_s2 & ~btn_q;

    // Receiver
    rx_state_t   rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_valid;
    logic        rx_tick, rx_half;

    assign rx_tick = (rx_cnt == BIT_LAST);
    assign rx_half = (rx_cnt == HALF_LAST);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_q && !rx_s2) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_valid <= rx_s2;  // low stop bit is a framing error: drop the byte
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    // Request slots and transmitter; echo wins over status when both are waiting
    logic       echo_pend, stat_pend;
    logic [7:0] echo_byte, stat_byte;
    tx_state_t  tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_tick, grant_echo, grant_stat, tx_go;

    assign tx_tick    = (tx_cnt == BIT_LAST);
    assign grant_echo = (tx_state == TX_IDLE) && echo_pend;
    assign grant_stat = (tx_state == TX_IDLE) && !echo_pend && stat_pend;
    assign tx_go      = grant_echo || grant_stat;

    always_comb begin
        tx_next  = tx_state;
        uart_txd = 1'b1;
        case (tx_state)
            TX_IDLE:  if (tx_go) tx_next = TX_START;
            TX_START: begin
                uart_txd = 1'b0;
                if (tx_tick) tx_next = TX_DATA;
            end
            TX_DATA: begin
                uart_txd = tx_shift[0];
                if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (grant_echo)      tx_shift <= echo_byte;
                    else if (grant_stat) tx_shift <= stat_byte;
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            endcase
        end
    end

    // A fresh request overrides the grant-clear so a same-cycle arrival is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_pend <= 1'b0;
            echo_byte <= '0;
            stat_pend <= 1'b0;
            stat_byte <= '0;
            led       <= '0;
        end else begin
            if (rx_valid) begin
                echo_pend <= 1'b1;
                echo_byte <= rx_shift;
            end else if (grant_echo) begin
                echo_pend <= 1'b0;
            end
            if (btn_edge[0]) begin
                stat_pend <= 1'b1;
                stat_byte <= sw_s2;
            end else if (grant_stat) begin
                stat_pend <= 1'b0;
            end
            if (rx_valid)         led <= rx_shift;
            else if (btn_edge[4]) led <= 8'h00;
            else if (btn_edge[2]) led <= ~led;
        end
    end

    logic [4:0] rst_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            rst_cnt <= '0;
        else if (!rst_cnt[4])  rst_cnt <= rst_cnt + 5'd1;
    end

    assign phy_reset_n = rst_cnt[4];
    assign uart_rts    = 1'b0;
    assign i2c_scl_o   = 1'b1;
    assign i2c_scl_t   = 1'b1;
    assign i2c_sda_o   = 1'b1;
    assign i2c_sda_t   = 1'b1;
    assign phy_gtx_clk = 1'b0;
    assign phy_txd     = 8'h00;
    assign phy_tx_en   = 1'b0;
    assign phy_tx_er   = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, i2c_scl_i, i2c_sda_i, phy_rx_clk, phy_rxd, phy_rx_dv, phy_rx_er,
                         phy_tx_clk, phy_int_n, uart_cts, btn_edge[3], btn_edge[1]};

endmodule

// File: tb/tb_fpga_core.sv
// Bench for fpga_core: drives UART frames and buttons, checks LEDs, reset behaviour and
// every transmitted frame bit-by-bit against an expected-byte queue.
module tb_fpga_core;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn = '0;  // {u, l, d, r, c}
    logic [7:0] sw = '0;
    logic       uart_rxd = 1'b1;
    logic [7:0] led, phy_txd;
    logic       i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
    logic       phy_gtx_clk, phy_tx_en, phy_tx_er, phy_reset_n, uart_txd, uart_rts;

    fpga_core #(.TARGET("SIM")) dut (
        .clk(clk), .rst_n(rst_n),
        .btnu(btn[4]), .btnl(btn[3]), .btnd(btn[2]), .btnr(btn[1]), .btnc(btn[0]),
        .sw(sw), .led(led),
        .i2c_scl_i(1'b1), .i2c_scl_o(i2c_scl_o), .i2c_scl_t(i2c_scl_t),
        .i2c_sda_i(1'b1), .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t),
        .phy_rx_clk(1'b0), .phy_rxd(8'h00), .phy_rx_dv(1'b0), .phy_rx_er(1'b0),
        .phy_gtx_clk(phy_gtx_clk), .phy_tx_clk(1'b0), .phy_txd(phy_txd),
        .phy_tx_en(phy_tx_en), .phy_tx_er(phy_tx_er), .phy_reset_n(phy_reset_n),
        .phy_int_n(1'b1), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .uart_cts(1'b0), .uart_rts(uart_rts)
    );

    // Clock / reset
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int frames_done = 0;
    int frame_start[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // TX monitor: compares every cycle of a frame with the 8N1 pattern of the expected byte
    initial begin : tx_mon
        logic [7:0] e, got;
        logic [9:0] pat;
        int errs, t0;
        bit aborted, have;
        forever begin
            @(negedge clk);
            if (rst_n && uart_txd === 1'b0) begin
                t0 = cyc;
                have = (exp_q.size() > 0);
                e = have ? exp_q.pop_front() : 8'h00;
                pat = {1'b1, e, 1'b0};
                errs = 0;
                got = '0;
                aborted = 0;
                for (int i = 0; i < 10 * C; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1;
                        break;
                    end
                    if (uart_txd !== pat[i / C]) errs++;
                    if (i % C == C / 2 && i / C >= 1 && i / C <= 8) got[i / C - 1] = uart_txd;
                end
                if (!aborted) begin
                    check("tx_expected", 32'(have), 32'd1);
                    check("tx_byte", 32'(got), 32'(e));
                    check("tx_shape", errs, 0);
                    frame_start.push_back(t0);
                    frames_done++;
                end
            end
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_q.push_back(b);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (C) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (C) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic pulse(input int idx);
        @(negedge clk);
        btn[idx] = 1'b1;
        repeat (4) @(negedge clk);
        btn[idx] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic press_status();
        exp_q.push_back(sw);
        pulse(0);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait", 32'(frames_done >= n), 32'd1);
    endtask

    // Stimulus
    initial begin
        int n0, gap;

        repeat (5) @(negedge clk);
        check("rst_led", led, 8'h00);
        check("rst_txd", uart_txd, 1'b1);
        check("rst_phy", phy_reset_n, 1'b0);
        check("rst_i2c", {i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t}, 4'hF);
        check("rst_gmii", {phy_gtx_clk, phy_txd, phy_tx_en, phy_tx_er}, 11'h000);
        check("rst_rts", uart_rts, 1'b0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("phy_rst_15", phy_reset_n, 1'b0);
        @(negedge clk);
        check("phy_rst_16", phy_reset_n, 1'b1);

        // Receive and echo
        n0 = frames_done;
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("rx_led_a5", led, 8'hA5);
        wait_frames(n0 + 1, 200);

        // Status report, switch moved mid-frame
        n0 = frames_done;
        sw = 8'h3C;
        press_status();
        repeat (20) @(negedge clk);
        sw = 8'h55;
        wait_frames(n0 + 1, 200);
        check("status_led_kept", led, 8'hA5);

        // RX completion and btnc edge in the same cycle
        n0 = frames_done;
        sw = 8'h22;
        fork
            send_byte(8'h11, 1'b1);
            begin
                @(negedge clk);
                repeat (77) @(negedge clk);
                exp_q.push_back(sw);
                btn[0] = 1'b1;
                repeat (4) @(negedge clk);
                btn[0] = 1'b0;
            end
        join
        wait_frames(n0 + 2, 400);
        gap = frame_start[frame_start.size() - 1] - frame_start[frame_start.size() - 2];
        check("b2b_gap", 32'(gap >= 80 && gap <= 81), 32'd1);
        check("cont_led", led, 8'h11);

        // LED buttons
        n0 = frames_done;
        send_byte(8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        check("led_0f", led, 8'h0F);
        wait_frames(n0 + 1, 200);
        pulse(2);
        check("btnd_f0", led, 8'hF0);
        pulse(4);
        check("btnu_00", led, 8'h00);
        pulse(2);
        check("btnd_ff", led, 8'hFF);
        pulse(3);
        check("btnl_none", led, 8'hFF);
        pulse(1);
        check("btnr_none", led, 8'hFF);

        // rx_valid beats btnu in the same cycle
        n0 = frames_done;
        fork
            send_byte(8'h5A, 1'b1);
            begin
                @(negedge clk);
                repeat (77) @(negedge clk);
                btn[4] = 1'b1;
                repeat (4) @(negedge clk);
                btn[4] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("prio_rx_btnu", led, 8'h5A);
        wait_frames(n0 + 1, 200);

        // btnu beats btnd in the same cycle
        @(negedge clk);
        btn[4] = 1'b1;
        btn[2] = 1'b1;
        repeat (4) @(negedge clk);
        btn[4] = 1'b0;
        btn[2] = 1'b0;
        repeat (6) @(negedge clk);
        check("prio_btnu_btnd", led, 8'h00);

        // Short start glitch and framing error
        n0 = frames_done;
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (120) @(negedge clk);
        check("glitch_led", led, 8'h00);
        check("glitch_no_tx", frames_done, n0);
        send_byte(8'h99, 1'b0);
        repeat (120) @(negedge clk);
        check("ferr_led", led, 8'h00);
        check("ferr_no_echo", frames_done, n0);
        send_byte(8'h42, 1'b1);
        repeat (4) @(negedge clk);
        check("rx_after_err", led, 8'h42);
        wait_frames(n0 + 1, 200);

        // Reset in the middle of a frame, during a zero data bit
        sw = 8'hC3;
        press_status();
        repeat (38) @(negedge clk);
        check("pre_rst_txd", uart_txd, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midtx_rst_txd", uart_txd, 1'b1);
        check("midtx_rst_led", led, 8'h00);
        check("midtx_rst_phy", phy_reset_n, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", uart_txd, 1'b1);
        check("post_rst_q", exp_q.size(), 0);

        n0 = frames_done;
        send_byte(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        check("recover_led", led, 8'h7E);
        wait_frames(n0 + 1, 200);
        repeat (20) @(negedge clk);
        check("final_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_core.md
FPGA_CORE -- requirements
Module: fpga_core

Interface
REQ-001 Parameter TARGET, default "SIM": "SIM" selects fast UART timing for simulation; any other value (e.g. "XILINX") selects hardware timing.
REQ-002 Derived constant CLKS_PER_BIT: 8 when TARGET=="SIM", otherwise 1085 (115200 baud at 125 MHz).
REQ-003 clk  in  1  single system clock, 125 MHz; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 btnu, btnl, btnd, btnr, btnc  in  1 each  push buttons, active-high, asynchronous.
REQ-006 sw  in  8  DIP switches, asynchronous.
REQ-007 led  out  8  LED register.
REQ-008 i2c_scl_i, i2c_sda_i  in  1 each  I2C inputs, unused.
REQ-009 i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t  out  1 each  I2C tristate controls; t=1 means released.
REQ-010 phy_rx_clk, phy_rx_dv, phy_rx_er, phy_tx_clk  in  1 each; phy_rxd  in  8  GMII inputs, unused.
REQ-011 phy_int_n  in  1  PHY interrupt, unused.
REQ-012 phy_gtx_clk  out  1; phy_txd  out  8; phy_tx_en, phy_tx_er  out  1 each  GMII transmit outputs.
REQ-013 phy_reset_n  out  1  PHY reset, active-low.
REQ-014 uart_rxd  in  1  UART serial input, idle high.
REQ-015 uart_txd  out  1  UART serial output, idle high.
REQ-016 uart_cts  in  1  flow-control input, ignored.
REQ-017 uart_rts  out  1  flow-control output.

Function
REQ-018 btn*, sw and uart_rxd SHALL each pass through a 2-flop synchronizer before use; reset values are 0, except uart_rxd, which resets to 1.
REQ-019 Button edge detect SHALL fire for exactly one cycle when the synchronized level goes 0->1; no debounce is required.
REQ-020 UART RX SHALL detect a start bit on a synchronized high->low transition while idle.
REQ-021 UART RX SHALL recheck the line at CLKS_PER_BIT/2 and return to idle if the line is high.
REQ-022 UART RX SHALL sample 8 data bits, LSB first, each CLKS_PER_BIT apart, then sample the stop bit.
REQ-023 UART RX FSM states: IDLE, START, DATA, STOP.
REQ-024 When the stop bit is 1, RX SHALL pulse rx_valid for one cycle with the byte; when the stop bit is 0 (framing error), the byte SHALL be discarded and RX SHALL return to IDLE.
REQ-025 UART TX SHALL send 8N1 (start 0, 8 data bits LSB first, stop 1), each bit exactly CLKS_PER_BIT cycles, for 10*CLKS_PER_BIT cycles total.
REQ-026 UART TX FSM states: IDLE, START, DATA, STOP; uart_txd SHALL be 1 in IDLE.
REQ-027 On rx_valid, led SHALL load the received byte on the following cycle, and an echo request for that byte SHALL be latched.
REQ-028 On a btnc edge, a status request carrying the synchronized sw value captured at that edge SHALL be latched.
REQ-029 Each request type SHALL have a one-deep pending slot; a new request of the same type SHALL overwrite its pending slot.
REQ-030 When TX is IDLE and requests are pending, the echo request SHALL be served before the status request.
REQ-031 TX SHALL start the frame the cycle after it is granted; it SHALL never be interrupted.
REQ-032 On a btnu edge, led SHALL become 0x00.
REQ-033 On a btnd edge, led SHALL become ~led.
REQ-034 Simultaneous led events in the same cycle SHALL resolve with priority rx_valid > btnu > btnd.
REQ-035 btnl and btnr SHALL have no effect.
REQ-036 I2C outputs SHALL be constant: i2c_scl_o=1, i2c_sda_o=1, i2c_scl_t=1, i2c_sda_t=1.
REQ-037 GMII outputs SHALL be constant: phy_gtx_clk=0, phy_txd=0, phy_tx_en=0, phy_tx_er=0.
REQ-038 phy_reset_n SHALL be 0 during reset and go to 1 once 16 cycles have elapsed after rst_n deasserts.
REQ-039 uart_rts SHALL be 0 at all times (always ready to receive).

Reset
REQ-040 While rst_n=0, all state SHALL clear asynchronously: led=0x00, uart_txd=1, both FSMs in IDLE, pending slots empty, phy_reset_n=0, reset counter=0.
REQ-041 Assertion of rst_n mid-frame SHALL abort TX immediately (uart_txd=1) and discard any partial RX byte.

Verification
REQ-042 Reset: hold rst_n=0 -> led=0x00, uart_txd=1, phy_reset_n=0, I2C t=1; release rst_n -> phy_reset_n=1 after 16 cycles.
REQ-043 RX/echo: TARGET="SIM", drive 8N1 0xA5 on uart_rxd -> led=0xA5; uart_txd emits 0xA5 frame of 80 cycles.
REQ-044 Status: sw=0x3C, pulse btnc -> uart_txd emits 0x3C; sw changed mid-frame does not alter the byte.
REQ-045 Contention: RX 0x11 completes in the same cycle as a btnc edge with sw=0x22 -> frames 0x11 then 0x22, back-to-back.
REQ-046 LED buttons: led=0x0F, pulse btnd -> 0xF0; pulse btnu -> 0x00; btnl/btnr -> unchanged.
REQ-047 Errors: start glitch shorter than 4 cycles -> no byte; stop bit 0 -> led unchanged, no echo; rst_n low mid-TX -> uart_txd=1 immediately.
